alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_ctrl_pkg.sv | 53 +++++
 rtl/alu_seq_ctrl_if.sv | 23 ++
 rtl/alu_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer.
// Holds the ALU opcodes, the command fn codes, the FSM state encoding and small decode helpers.
package alu_seq_ctrl_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_NOR = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLL = 3'd7;

    localparam logic [3:0] FN_AND = 4'd0;
    localparam logic [3:0] FN_OR  = 4'd1;
    localparam logic [3:0] FN_ADD = 4'd2;
    localparam logic [3:0] FN_SUB = 4'd3;
    localparam logic [3:0] FN_SLT = 4'd4;
    localparam logic [3:0] FN_NOR = 4'd5;
    localparam logic [3:0] FN_SRL = 4'd6;
    localparam logic [3:0] FN_SLL = 4'd7;
    localparam logic [3:0] FN_MUL = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXEC      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_MUL_ADD   = 3'd3,
        ST_MUL_SHIFT = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    function automatic logic [2:0] fn_to_alu_op(input logic [3:0] fn);
        case (fn)
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_SLT:  return ALU_SLT;
            FN_NOR:  return ALU_NOR;
            FN_SRL:  return ALU_SRL;
            FN_SLL:  return ALU_SLL;
            default: return ALU_AND;
        endcase
    endfunction

    // Signed less-than from the raw A-B difference: when the signs differ the
    // difference may have overflowed, so the sign of A alone decides.
    function automatic logic slt_bit(input logic a_msb, input logic b_msb, input logic diff_msb);
        return (a_msb ^ b_msb) ? a_msb : diff_msb;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command/response handshake bundle between a requester and the ALU sequencer.
interface alu_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [3:0]      cmd_fn;
    logic [XLEN-1:0] cmd_a;
    logic [XLEN-1:0] cmd_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_fn, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_fn, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle command sequencer driving an external single-cycle 32-bit ALU.
// Builds variable shifts, signed SLT and a shift-add multiply out of the ALU primitives.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_ctrl_if.slave    bus,
    output logic             busy,
    output logic [XLEN-1:0]  alu_in0,
    output logic [XLEN-1:0]  alu_in1,
    output logic [2:0]       alu_op,
    input  logic [XLEN-1:0]  alu_out
);

    state_t          state_reg, state_next;
    logic [3:0]      fn_reg, fn_next;
    logic [XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0] mcand_reg, mcand_next;
    logic [XLEN-1:0] mplier_reg, mplier_next;
    logic [4:0]      cnt_reg, cnt_next;
    logic            rsp_valid_reg, rsp_valid_next;
    logic [XLEN-1:0] rsp_data_reg, rsp_data_next;

    assign bus.cmd_ready = (state_reg == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign busy          = (state_reg != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            fn_reg        <= '0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            cnt_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            fn_reg        <= fn_next;
            acc_reg       <= acc_next;
            mcand_reg     <= mcand_next;
            mplier_reg    <= mplier_next;
            cnt_reg       <= cnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        fn_next        = fn_reg;
        acc_next       = acc_reg;
        mcand_next     = mcand_reg;
        mplier_next    = mplier_reg;
        cnt_next       = cnt_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        alu_op         = ALU_AND;
        alu_in0        = '0;
        alu_in1        = '0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    // EXEC reads A/B from acc/mcand; for non-ALU fns it returns
                    // acc directly, so acc carries the pass-through value.
                    fn_next     = bus.cmd_fn;
                    acc_next    = '0;
                    mcand_next  = '0;
                    mplier_next = '0;
                    cnt_next    = '0;
                    state_next  = ST_EXEC;
                    if (bus.cmd_fn <= FN_NOR) begin
                        acc_next   = bus.cmd_a;
                        mcand_next = bus.cmd_b;
                    end else if (bus.cmd_fn == FN_SRL || bus.cmd_fn == FN_SLL) begin
                        acc_next = bus.cmd_a;
                        cnt_next = bus.cmd_b[4:0];
                        if (bus.cmd_b[4:0] != 5'd0) begin
                            state_next = ST_SHIFT;
                        end
                    end else if (bus.cmd_fn == FN_MUL && MUL_EN) begin
                        mcand_next  = bus.cmd_a;
                        mplier_next = bus.cmd_b;
                        if (bus.cmd_b != '0) begin
                            state_next = bus.cmd_b[0] ? ST_MUL_ADD : ST_MUL_SHIFT;
                        end
                    end
                end
            end

            ST_EXEC: begin
                if (fn_reg <= FN_NOR) begin
                    alu_op  = fn_to_alu_op(fn_reg);
                    alu_in0 = acc_reg;
                    alu_in1 = mcand_reg;
                    if (fn_reg == FN_SLT) begin
                        rsp_data_next = {{(XLEN-1){1'b0}},
                                         slt_bit(acc_reg[XLEN-1], mcand_reg[XLEN-1], alu_out[XLEN-1])};
                    end else begin
                        rsp_data_next = alu_out;
                    end
                end else begin
                    rsp_data_next = acc_reg;
                end
                rsp_valid_next = 1'b1;
                state_next     = ST_DONE;
            end

            ST_SHIFT: begin
                alu_op   = (fn_reg == FN_SRL) ? ALU_SRL : ALU_SLL;
                alu_in0  = acc_reg;
                acc_next = alu_out;
                cnt_next = cnt_reg - 5'd1;
                if (cnt_reg == 5'd1) begin
                    rsp_data_next  = alu_out;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_DONE;
                end
            end

            ST_MUL_ADD: begin
                alu_op     = ALU_ADD;
                alu_in0    = acc_reg;
                alu_in1    = mcand_reg;
                acc_next   = alu_out;
                state_next = ST_MUL_SHIFT;
            end

            ST_MUL_SHIFT: begin
                alu_op      = ALU_SLL;
                alu_in0     = mcand_reg;
                mcand_next  = alu_out;
                mplier_next = mplier_reg >> 1;
                if (mplier_next == '0) begin
                    rsp_data_next  = acc_reg;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_DONE;
                end else begin
                    state_next = mplier_next[0] ? ST_MUL_ADD : ST_MUL_SHIFT;
                end
            end

            ST_DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: table of commands with hand-computed results and
// latencies, plus hand-written backpressure, multiply-sequence and mid-operation reset cases.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [31:0] alu_in0, alu_in1, alu_out;
    logic [2:0]  alu_op;

    alu_seq_ctrl_if #(.XLEN(32)) bus ();

    alu_seq_ctrl #(.XLEN(32), .MUL_EN(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .alu_in0 (alu_in0),
        .alu_in1 (alu_in1),
        .alu_op  (alu_op),
        .alu_out (alu_out)
    );

    always #5 clk = ~clk;

    // Stand-in for the neighbouring ALU32
    always_comb begin
        case (alu_op)
            3'd0:    alu_out = alu_in0 & alu_in1;
            3'd1:    alu_out = alu_in0 | alu_in1;
            3'd2:    alu_out = alu_in0 + alu_in1;
            3'd3:    alu_out = alu_in0 - alu_in1;
            3'd4:    alu_out = alu_in0 - alu_in1;
            3'd5:    alu_out = ~(alu_in0 | alu_in1);
            3'd6:    alu_out = alu_in0 >> 1;
            default: alu_out = alu_in0 << 1;
        endcase
    end

    typedef struct {
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        int          exp_lat;
        logic [3:0]  exp_op;   // 4'hF: do not check per-cycle opcode
    } vec_t;

    localparam int NVEC = 22;
    vec_t vt [NVEC];

    int vectors = 0;
    int miscompares = 0;
    logic [2:0] op_hist [128];
    int n_ops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] fn, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] exp_op,
                           output logic [31:0] data, output int lat);
        int   wait_cnt;
        logic [3:0] bad_op;
        bad_op = exp_op;
        @(negedge clk);
        wait_cnt = 0;
        while (!bus.cmd_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check({tag, "_ready_wait"}, {31'b0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_fn    = fn;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(posedge clk);
        #1;
        // Scramble operands after accept; the DUT must have latched them
        bus.cmd_valid = 1'b0;
        bus.cmd_fn    = 4'd2;
        bus.cmd_a     = 32'hDEAD_BEEF;
        bus.cmd_b     = 32'h0BAD_F00D;
        lat   = 0;
        n_ops = 0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) break;
            if (lat >= 200) break;
            if (n_ops < 128) op_hist[n_ops] = alu_op;
            n_ops++;
            if (exp_op != 4'hF && {1'b0, alu_op} != exp_op && bad_op == exp_op)
                bad_op = {1'b0, alu_op};
            lat++;
        end
        check({tag, "_rsp_seen"}, {31'b0, bus.rsp_valid}, 32'd1);
        data = bus.rsp_data;
        if (exp_op != 4'hF) check({tag, "_alu_op"}, {28'b0, bad_op}, {28'b0, exp_op});
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_after"}, {30'b0, bus.cmd_ready, bus.rsp_valid}, 32'b10);
    endtask

    initial begin
        logic [31:0] data;
        int          lat;
        logic        stable;
        logic        seen;

        vt[0]  = '{FN_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1, 4'd0};
        vt[1]  = '{FN_OR,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1, 4'd1};
        vt[2]  = '{FN_ADD, 32'd5,         32'd3,         32'd8,         1, 4'd2};
        vt[3]  = '{FN_ADD, 32'hFFFF_FFFF, 32'd2,         32'd1,         1, 4'd2};
        vt[4]  = '{FN_SUB, 32'd1,         32'd1,         32'd0,         1, 4'd3};
        vt[5]  = '{FN_SUB, 32'd0,         32'd1,         32'hFFFF_FFFF, 1, 4'd3};
        vt[6]  = '{FN_SLT, 32'hFFFF_FFFF, 32'd1,         32'd1,         1, 4'd4};
        vt[7]  = '{FN_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         1, 4'd4};
        vt[8]  = '{FN_SLT, 32'd3,         32'd5,         32'd1,         1, 4'd4};
        vt[9]  = '{FN_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1, 4'd4};
        vt[10] = '{FN_NOR, 32'd0,         32'd0,         32'hFFFF_FFFF, 1, 4'd5};
        vt[11] = '{FN_SLL, 32'd1,         32'd31,        32'h8000_0000, 31, 4'd7};
        vt[12] = '{FN_SRL, 32'h8000_0000, 32'h0000_0025, 32'h0400_0000, 5, 4'd6};
        vt[13] = '{FN_SLL, 32'h1234_5678, 32'd0,         32'h1234_5678, 1, 4'd0};
        vt[14] = '{FN_SRL, 32'hF000_0000, 32'd4,         32'h0F00_0000, 4, 4'd6};
        vt[15] = '{FN_MUL, 32'd3,         32'd5,         32'd15,        5, 4'hF};
        vt[16] = '{FN_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         64, 4'hF};
        vt[17] = '{FN_MUL, 32'd7,         32'd0,         32'd0,         1, 4'd0};
        vt[18] = '{FN_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0,         18, 4'hF};
        vt[19] = '{FN_MUL, 32'd1234,      32'd1000,      32'h0012_D450, 16, 4'hF};
        vt[20] = '{4'd12,  32'h1111_2222, 32'h3333_4444, 32'd0,         1, 4'd0};
        vt[21] = '{4'd15,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1, 4'd0};

        bus.cmd_valid = 1'b0;
        bus.cmd_fn    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("reset_rsp_data", bus.rsp_data, 32'd0);
        check("reset_ready_busy", {30'b0, bus.cmd_ready, busy}, 32'b10);
        check("reset_alu_drive", {29'b0, alu_op} | alu_in0 | alu_in1, 32'd0);
        rst_n = 1'b1;
        $display("reset released");

        for (int i = 0; i < NVEC; i++) begin
            run_cmd($sformatf("v%0d", i), vt[i].fn, vt[i].a, vt[i].b, vt[i].exp_op, data, lat);
            check($sformatf("v%0d_data", i), data, vt[i].exp_data);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            $display("vec %0d fn=%0d a=0x%08h b=0x%08h data=0x%08h lat=%0d",
                     i, vt[i].fn, vt[i].a, vt[i].b, data, lat);
        end

        // Multiply 3*5 walks ADD, SHIFT, SHIFT, ADD, SHIFT
        run_cmd("mulseq", FN_MUL, 32'd3, 32'd5, 4'hF, data, lat);
        check("mulseq_ops", {17'b0, op_hist[0], op_hist[1], op_hist[2], op_hist[3], op_hist[4]},
              {17'b0, 3'd2, 3'd7, 3'd7, 3'd2, 3'd7});
        $display("mul sequence 3*5 data=0x%08h lat=%0d", data, lat);

        // Backpressure: response held for 10 cycles while a new command waits
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_fn = FN_ADD; bus.cmd_a = 32'd10; bus.cmd_b = 32'd20;
        @(posedge clk);
        #1;
        bus.cmd_fn = FN_SUB; bus.cmd_a = 32'd9; bus.cmd_b = 32'd4;
        @(negedge clk);
        @(negedge clk);
        check("bp_first_rsp", {31'b0, bus.rsp_valid}, 32'd1);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!bus.rsp_valid || bus.rsp_data !== 32'd30 || bus.cmd_ready) stable = 1'b0;
            @(negedge clk);
        end
        check("bp_hold_stable", {31'b0, stable}, 32'd1);
        check("bp_hold_data", bus.rsp_data, 32'd30);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_release_idle", {29'b0, bus.cmd_ready, bus.rsp_valid, busy}, 32'b100);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_pending_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("bp_pending_data", {31'b0, bus.rsp_valid} ^ 32'd0, 32'd1);
        check("bp_pending_value", bus.rsp_data, 32'd5);
        $display("backpressure held response 0x%08h, pending SUB gave 0x%08h", 32'd30, bus.rsp_data);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;

        // Reset during a long multiply drops it without a response
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_fn = FN_MUL; bus.cmd_a = 32'd7; bus.cmd_b = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mid_busy_before", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_mid_ready", {31'b0, bus.cmd_ready}, 32'd1);
        check("rst_mid_rsp_data", bus.rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.rsp_valid || busy) seen = 1'b1;
        end
        check("rst_no_late_rsp", {31'b0, seen}, 32'd0);
        $display("reset mid-MUL dropped the command");

        run_cmd("post_rst", FN_ADD, 32'd100, 32'd23, 4'd2, data, lat);
        check("post_rst_data", data, 32'd123);
        check("post_rst_latency", 32'(lat), 32'd1);
        $display("post-reset ADD data=0x%08h lat=%0d", data, lat);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, 0 of 1 expected completions");
        $fatal(1, "watchdog");
    end

endmodule
